// File: rtl/free_list_nway.sv
// N-wide physical-register free list for the rename stage: all-or-nothing multi-lane allocation,
// multi-lane retire, checkpointable head. Optional debug outputs under FREE_LIST_DEBUG_EN.
module free_list_nway #(
    parameter int unsigned PREG_NUM   = 64,
    parameter int unsigned AREG_NUM   = 32,
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned RETIRE_W   = 2,
    localparam int unsigned PREG_W    = $clog2(PREG_NUM),
    localparam int unsigned DEPTH     = PREG_NUM - AREG_NUM,
    localparam int unsigned PTR_W     = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DISPATCH_W-1:0]        dispatch_req_i,
    output logic                         dispatch_gnt_o,
    output logic [DISPATCH_W*PREG_W-1:0] free_preg_o,
    output logic [PTR_W-1:0]             free_head_o,
    input  logic [RETIRE_W-1:0]          retire_en_i,
    input  logic [RETIRE_W*PREG_W-1:0]   retire_preg_i,
    input  logic                         recover_en_i,
    input  logic [PTR_W-1:0]             recover_head_i,
`ifdef FREE_LIST_DEBUG_EN
    output logic [PTR_W-1:0]             head_dbg_o,
    output logic [PTR_W-1:0]             tail_dbg_o,
    output logic                         overflow_err_o,
`endif
    output logic [PTR_W-1:0]             count_o
);

    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PREG_W-1:0] fl_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  occ;
    logic              gnt;
    int unsigned       nreq, nret, space, nacc;
    logic [RETIRE_W-1:0] wr_en;
    logic [IDX_W-1:0]  wr_idx [RETIRE_W];

    assign count_o        = tail_q - head_q;
    assign free_head_o    = head_q;
    assign dispatch_gnt_o = gnt;

    always_comb begin : alloc
        int unsigned k;
        nreq = 0;
        for (int unsigned i = 0; i < DISPATCH_W; i++) begin
            nreq += 32'(dispatch_req_i[i]);
        end
        gnt = (nreq != 0) && (nreq <= 32'(count_o)) && !recover_en_i;
        free_preg_o = '0;
        k = 0;
        for (int unsigned i = 0; i < DISPATCH_W; i++) begin
            if (dispatch_req_i[i]) begin
                if (gnt) begin
                    free_preg_o[i*PREG_W +: PREG_W] = fl_q[IDX_W'(head_q + PTR_W'(k))];
                end
                k++;
            end
        end
        head_d = recover_en_i ? recover_head_i : (gnt ? head_q + PTR_W'(nreq) : head_q);
    end

    // Room is measured against the post-recover head so a restore never lets tail pass head+DEPTH.
    always_comb begin : retire
        int unsigned k;
        occ   = tail_q - (recover_en_i ? recover_head_i : head_q);
        space = (32'(occ) > DEPTH) ? 0 : DEPTH - 32'(occ);
        wr_en = '0;
        k     = 0;
        for (int unsigned j = 0; j < RETIRE_W; j++) begin
            wr_idx[j] = IDX_W'(tail_q + PTR_W'(k));
            if (retire_en_i[j]) begin
                wr_en[j] = (k < space);
                k++;
            end
        end
        nret   = k;
        nacc   = (nret < space) ? nret : space;
        tail_d = tail_q + PTR_W'(nacc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= PTR_W'(DEPTH);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fl_q[i] <= PREG_W'(AREG_NUM + i);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int unsigned j = 0; j < RETIRE_W; j++) begin
                if (wr_en[j]) begin
                    fl_q[wr_idx[j]] <= retire_preg_i[j*PREG_W +: PREG_W];
                end
            end
        end
    end

`ifdef FREE_LIST_DEBUG_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((nret > space) || (32'(occ) > DEPTH)) begin
            err_q <= 1'b1;
        end
    end

    assign head_dbg_o     = head_q;
    assign tail_dbg_o     = tail_q;
    assign overflow_err_o = err_q;
`endif

endmodule
